// File: rtl/pong_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pong_pkg: font ROM geometry and text-overlay requester indices.
// Revision: 1.0
// ---------------------------------------------------------------------------
package pong_pkg;

  localparam int FONT_ADDR_W = 11;
  localparam int FONT_DATA_W = 8;
  localparam int FONT_N_REQ  = 4;

  localparam int REQ_SCORE = 0;
  localparam int REQ_LOGO  = 1;
  localparam int REQ_RULE  = 2;
  localparam int REQ_OVER  = 3;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arbiter: combinational rotating-priority pick starting at ptr.
// Revision: 1.0
// ---------------------------------------------------------------------------
module rr_arbiter
  import pong_pkg::*;
#(
  parameter int N     = FONT_N_REQ,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] idx
);

  logic             found;
  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      // ptr < N and i < N, so a single conditional subtract gives the modulo
      sum = {1'b0, ptr} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(N)) sum = sum - (PTR_W+1)'(N);
      cand = sum[PTR_W-1:0];
      if (en && !found && req[cand]) begin
        gnt[cand] = 1'b1;
        idx       = cand;
        found     = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/font_rom_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// font_rom_arbiter: round-robin sharing of the font ROM with tagged read return.
// Revision: 1.0
// ---------------------------------------------------------------------------
module font_rom_arbiter
  import pong_pkg::*;
#(
  parameter int N_REQ   = FONT_N_REQ,
  parameter int ADDR_W  = FONT_ADDR_W,
  parameter int DATA_W  = FONT_DATA_W,
  parameter int ROM_LAT = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    hold,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        gnt,
  output logic                    rom_en,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [DATA_W-1:0]       rom_data,
  output logic [DATA_W-1:0]       rdata,
  output logic [N_REQ-1:0]        rvalid
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  pick;
  logic              accept;
  logic [ADDR_W-1:0] addr_arr [N_REQ];
  logic              tag_vld  [ROM_LAT];
  logic [PTR_W-1:0]  tag_idx  [ROM_LAT];

  generate
    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
    end
  endgenerate

  // Gating with reset_n keeps gnt low for the whole time reset is held
  rr_arbiter #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req (req),
    .ptr (ptr),
    .en  (reset_n & ~hold),
    .gnt (gnt),
    .idx (pick)
  );

  assign accept = |gnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr      <= '0;
      rom_en   <= 1'b0;
      rom_addr <= '0;
      rdata    <= '0;
      rvalid   <= '0;
      for (int s = 0; s < ROM_LAT; s++) begin
        tag_vld[s] <= 1'b0;
        tag_idx[s] <= '0;
      end
    end else begin
      rom_en <= accept;
      if (accept) begin
        rom_addr <= addr_arr[pick];
        ptr      <= (pick == PTR_W'(N_REQ-1)) ? '0 : pick + 1'b1;
      end

      tag_vld[0] <= accept;
      tag_idx[0] <= pick;
      for (int s = 1; s < ROM_LAT; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_idx[s] <= tag_idx[s-1];
      end

      // The last stage lines up with the cycle rom_data is valid for its read
      rvalid <= '0;
      if (tag_vld[ROM_LAT-1]) begin
        rdata  <= rom_data;
        rvalid <= N_REQ'(1) << tag_idx[ROM_LAT-1];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_font_rom_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_font_rom_arbiter: directed checks of grant order, issue, return and reset.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_font_rom_arbiter;
  import pong_pkg::*;

  localparam int N  = 4;
  localparam int AW = 11;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          hold = 1'b0;
  logic [N-1:0]  req = '0;
  logic [AW-1:0] a [N];
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]  gnt;
  logic          rom_en;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic [DW-1:0] rdata;
  logic [N-1:0]  rvalid;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  assign req_addr = {a[3], a[2], a[1], a[0]};

  function automatic logic [DW-1:0] romf(input logic [AW-1:0] ad);
    return ad[7:0] ^ {ad[10:8], ad[4:0]};
  endfunction

  // Asynchronous-read ROM model: data follows the registered address
  assign rom_data = romf(rom_addr);

  font_rom_arbiter dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .hold     (hold),
    .req      (req),
    .req_addr (req_addr),
    .gnt      (gnt),
    .rom_en   (rom_en),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .rdata    (rdata),
    .rvalid   (rvalid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    a[0] = 11'h010;
    a[1] = 11'h155;
    a[2] = 11'h2A3;
    a[3] = 11'h7FF;

    // Reset state, gnt forced low even with all requests up
    tick; tick;
    req = 4'b1111; #1;
    check("rst_gnt", gnt, 4'b0000);
    check("rst_rom_en", rom_en, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rvalid", rvalid, 0);

    // Single requester: logo at 0x155
    tick; reset_n = 1'b1; req = 4'b0010; #1;
    check("single_gnt", gnt, 4'b0010);
    tick; req = 4'b0000; #1;
    check("single_gnt_off", gnt, 4'b0000);
    check("single_rom_en", rom_en, 1);
    check("single_rom_addr", rom_addr, 11'h155);
    tick; #1;
    check("single_rvalid", rvalid, 4'b0010);
    check("single_rdata", rdata, romf(11'h155));
    check("single_rom_en_off", rom_en, 0);

    // ptr=2, req=1011: 3 then 0 then 1
    tick; req = 4'b1011; #1;
    check("rot_gnt3", gnt, 4'b1000);
    check("rot_rvalid_idle", rvalid, 4'b0000);
    tick; req = 4'b0011; #1;
    check("rot_gnt0", gnt, 4'b0001);
    check("rot_addr3", rom_addr, a[3]);
    tick; req = 4'b0010; #1;
    check("rot_gnt1", gnt, 4'b0010);
    check("rot_addr0", rom_addr, a[0]);
    check("rot_rv3", rvalid, 4'b1000);
    check("rot_rd3", rdata, romf(a[3]));
    tick; req = 4'b0000; #1;
    check("rot_gnt_none", gnt, 4'b0000);
    check("rot_rv0", rvalid, 4'b0001);
    check("rot_rd0", rdata, romf(a[0]));
    tick; #1;
    check("rot_rv1", rvalid, 4'b0010);
    check("rot_rd1", rdata, romf(a[1]));

    // All four continuously from reset
    tick; reset_n = 1'b0; #1;
    tick; reset_n = 1'b1; req = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) tick;
      #1;
      check("rr_gnt", gnt, 32'(4'b0001 << (c % 4)));
      if (c >= 1) check("rr_rom_addr", rom_addr, a[(c-1) % 4]);
      if (c >= 2) begin
        check("rr_rvalid", rvalid, 32'(4'b0001 << ((c-2) % 4)));
        check("rr_rdata", rdata, romf(a[(c-2) % 4]));
      end
    end

    // hold with all requesting: in-flight reads still return
    for (int h = 0; h < 5; h++) begin
      tick; hold = 1'b1; #1;
      check("hold_gnt", gnt, 4'b0000);
      if (h == 0) begin
        check("hold_rom_en0", rom_en, 1);
        check("hold_rom_addr0", rom_addr, a[3]);
        check("hold_rv2", rvalid, 4'b0100);
        check("hold_rd2", rdata, romf(a[2]));
      end else begin
        check("hold_rom_en", rom_en, 0);
        if (h == 1) begin
          check("hold_rv3", rvalid, 4'b1000);
          check("hold_rd3", rdata, romf(a[3]));
        end else begin
          check("hold_rv_none", rvalid, 4'b0000);
        end
      end
    end
    tick; hold = 1'b0; #1;
    check("unhold_gnt", gnt, 4'b0001);

    // Reset one cycle after a grant discards in-flight reads
    tick; req = 4'b0010; #1;
    check("pre_rst_gnt", gnt, 4'b0010);
    tick; reset_n = 1'b0; req = 4'b1111; #1;
    check("mid_rst_gnt", gnt, 4'b0000);
    check("mid_rst_rom_en", rom_en, 0);
    check("mid_rst_rom_addr", rom_addr, 0);
    check("mid_rst_rvalid", rvalid, 4'b0000);
    check("mid_rst_rdata", rdata, 0);
    tick; reset_n = 1'b1; req = 4'b0100; #1;
    check("post_rst_gnt", gnt, 4'b0100);
    check("post_rst_rvalid", rvalid, 4'b0000);
    tick; req = 4'b0000; #1;
    check("post_rst_rvalid2", rvalid, 4'b0000);
    check("post_rst_rom_addr", rom_addr, a[2]);
    tick; #1;
    check("post_rst_rv2", rvalid, 4'b0100);
    check("post_rst_rd2", rdata, romf(a[2]));

    // Requester 3 withdraws while 0 is granted; ptr lands on 1
    tick; req = 4'b1000; #1;
    check("wd_gnt3", gnt, 4'b1000);
    tick; req = 4'b1001; #1;
    check("wd_gnt0", gnt, 4'b0001);
    tick; req = 4'b0000; #1;
    check("wd_gnt_none", gnt, 4'b0000);
    check("wd_rv3_prior", rvalid, 4'b1000);
    tick; #1;
    check("wd_rv0", rvalid, 4'b0001);
    check("wd_rd0", rdata, romf(a[0]));
    tick; req = 4'b1001; #1;
    check("wd_ptr1_gnt", gnt, 4'b1000);
    check("wd_no_rv3", rvalid, 4'b0000);
    tick; req = 4'b0000; #1;
    check("wd_final_rom_addr", rom_addr, a[REQ_OVER]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
